// File: rtl/lenet_pkg.sv
// rtl/lenet_pkg.sv - shared window geometry constants and window-generator FSM states
package lenet_pkg;

    localparam int K        = 5;
    localparam int PIX_W    = 8;
    localparam int WIN_TAPS = K * K;
    localparam int WIN_W    = WIN_TAPS * PIX_W;
    localparam int NUM_LB   = K - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } win_state_e;

    // Bit offset of window tap (r, c) inside the flattened window bus.
    function automatic int tap_lsb(input int r, input int c);
        return (r * K + c) * PIX_W;
    endfunction

endpackage

// File: rtl/line_buf.sv
// rtl/line_buf.sv - one-row pixel delay, read-before-write at the current column
module line_buf
    import lenet_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem_q [DEPTH];

    // Reading combinationally returns the pixel written one row ago at this column.
    assign rdata = mem_q[addr];

    // Storage is deliberately unreset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - streaming 5x5 sliding-window generator for the convolution PE
module conv_window_gen
    import lenet_pkg::*;
#(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pix_valid,
    input  logic [7:0]       pix_in,
    output logic             pix_ready,
    output logic             win_valid,
    output logic [199:0]     win_out,
    output logic             frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_WIN0 = CW'(K - 1);
    localparam logic [RW-1:0] ROW_WIN0 = RW'(K - 1);

    win_state_e       state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [WIN_W-1:0] win_reg_q, win_reg_d;
    logic [WIN_W-1:0] win_out_q, win_out_d;
    logic             win_valid_q, win_valid_d;
    logic             frame_done_q, frame_done_d;

    logic             xfer;
    logic             win_complete;
    logic             last_pix;
    logic [PIX_W-1:0] lb_in  [NUM_LB];
    logic [PIX_W-1:0] lb_out [NUM_LB];
    logic [PIX_W-1:0] new_col [K];
    logic [WIN_W-1:0] win_shift;

    assign pix_ready    = (state_q == ST_LOAD);
    assign xfer         = pix_valid & pix_ready;
    assign win_complete = (row_q >= ROW_WIN0) && (col_q >= COL_WIN0);
    assign last_pix     = (row_q == ROW_LAST) && (col_q == COL_LAST);

    assign win_valid  = win_valid_q;
    assign win_out    = win_out_q;
    assign frame_done = frame_done_q;

    // Cascade of row delays: lb0 sees the incoming pixel, each later buffer the previous one's output.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LB; gi++) begin : g_lb
            if (gi == 0) begin : g_head
                assign lb_in[gi] = pix_in;
            end else begin : g_chain
                assign lb_in[gi] = lb_out[gi-1];
            end
            line_buf #(
                .DEPTH (IMG_W),
                .AW    (CW)
            ) u_line_buf (
                .clk   (clk),
                .we    (xfer),
                .addr  (col_q),
                .wdata (lb_in[gi]),
                .rdata (lb_out[gi])
            );
        end
    endgenerate

    // Incoming column, top (oldest row) to bottom (current pixel).
    always_comb begin
        for (int r = 0; r < K; r++) begin
            new_col[r] = '0;
        end
        new_col[K-1] = pix_in;
        for (int r = 0; r < K - 1; r++) begin
            new_col[r] = lb_out[NUM_LB-1-r];
        end
    end

    // Window after this transfer: columns move left, the new column enters at the right.
    always_comb begin
        win_shift = win_reg_q;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                if (c < K - 1) begin
                    win_shift[tap_lsb(r, c) +: PIX_W] = win_reg_q[tap_lsb(r, c + 1) +: PIX_W];
                end else begin
                    win_shift[tap_lsb(r, c) +: PIX_W] = new_col[r];
                end
            end
        end
    end

    // Frame sequencing and raster position tracking.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    if (last_pix) begin
                        state_d = ST_DONE;
                        col_d   = '0;
                        row_d   = '0;
                    end else if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            ST_DONE: begin
                frame_done_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Window register advances only on a transfer; the output copy updates only on a complete window.
    always_comb begin
        win_reg_d   = win_reg_q;
        win_out_d   = win_out_q;
        win_valid_d = 1'b0;
        if (xfer) begin
            win_reg_d = win_shift;
            if (win_complete) begin
                win_out_d   = win_shift;
                win_valid_d = 1'b1;
            end
        end
    end

    // State, counters, window and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            win_reg_q    <= '0;
            win_out_q    <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_reg_q    <= win_reg_d;
            win_out_q    <= win_out_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - self-checking bench for conv_window_gen against a raster-slice model
module tb_conv_window_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         a_start = 1'b0, a_pv = 1'b0;
    logic [7:0]   a_pix = 8'd0;
    logic         a_pr, a_wv, a_fd;
    logic [199:0] a_wo;

    logic         b_start = 1'b0, b_pv = 1'b0;
    logic [7:0]   b_pix = 8'd0;
    logic         b_pr, b_wv, b_fd;
    logic [199:0] b_wo;

    conv_window_gen #(.IMG_W(8), .IMG_H(8)) u_small (
        .clk(clk), .rst(rst), .start(a_start), .pix_valid(a_pv), .pix_in(a_pix),
        .pix_ready(a_pr), .win_valid(a_wv), .win_out(a_wo), .frame_done(a_fd)
    );

    conv_window_gen u_dflt (
        .clk(clk), .rst(rst), .start(b_start), .pix_valid(b_pv), .pix_in(b_pix),
        .pix_ready(b_pr), .win_valid(b_wv), .win_out(b_wo), .frame_done(b_fd)
    );

    int n_cmp = 0;
    int n_err = 0;

    int           phase     [2];
    int           nidx      [2];
    logic [7:0]   pix_mem   [2][1024];
    logic         exp_wv    [2];
    logic         exp_fd    [2];
    logic [199:0] exp_win   [2];
    logic [199:0] last_win  [2];
    int           win_cnt   [2];
    int           fd_cnt    [2];
    int           first_idx [2];
    logic [199:0] first_obs [2];
    logic [199:0] last_obs  [2];

    task automatic chk(input string name, input int id, input logic [199:0] act, input logic [199:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut=%0d t=%0t act=%h exp=%h", name, id, $time, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int id, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s dut=%0d t=%0t act=%0d exp=%0d", name, id, $time, act, exp);
        end
    endtask

    function automatic int tap(input logic [199:0] w, input int k);
        return int'(w[k*8 +: 8]);
    endfunction

    task automatic model_reset(input int id);
        phase[id]    = 0;
        nidx[id]     = 0;
        exp_wv[id]   = 1'b0;
        exp_fd[id]   = 1'b0;
        last_win[id] = '0;
    endtask

    // Checks what the DUT shows now, then predicts the next cycle from the pixels seen so far.
    task automatic step(input int id, input int w, input int h, input logic st, input logic pv,
                        input logic [7:0] px, input logic pr, input logic wv,
                        input logic [199:0] wo, input logic fd);
        logic [199:0] wbuf;
        int n, r, c;
        if (!rst) begin
            chk("rst_pix_ready", id, 200'(pr), '0);
            chk("rst_win_valid", id, 200'(wv), '0);
            chk("rst_frame_done", id, 200'(fd), '0);
            chk("rst_win_out", id, wo, '0);
            model_reset(id);
        end else begin
            chk("win_valid", id, 200'(wv), 200'(exp_wv[id]));
            if (exp_wv[id]) begin
                chk("win_out", id, wo, exp_win[id]);
                last_win[id] = exp_win[id];
            end else begin
                chk("win_hold", id, wo, last_win[id]);
            end
            chk("frame_done", id, 200'(fd), 200'(exp_fd[id]));
            chk("pix_ready", id, 200'(pr), 200'(phase[id] == 1));
            if (wv) begin
                win_cnt[id]++;
                if (win_cnt[id] == 1) first_obs[id] = wo;
                last_obs[id] = wo;
            end
            if (fd) fd_cnt[id]++;
            exp_wv[id] = 1'b0;
            exp_fd[id] = 1'b0;
            if (phase[id] == 0) begin
                if (st) begin
                    phase[id]     = 1;
                    nidx[id]      = 0;
                    win_cnt[id]   = 0;
                    fd_cnt[id]    = 0;
                    first_idx[id] = -1;
                end
            end else if (phase[id] == 1) begin
                if (pv) begin
                    n = nidx[id];
                    pix_mem[id][n] = px;
                    r = n / w;
                    c = n % w;
                    if (r >= 4 && c >= 4) begin
                        wbuf = '0;
                        for (int rr = 0; rr < 5; rr++)
                            for (int cc = 0; cc < 5; cc++)
                                wbuf[(rr*5+cc)*8 +: 8] = pix_mem[id][(r-4+rr)*w + (c-4+cc)];
                        exp_win[id] = wbuf;
                        exp_wv[id]  = 1'b1;
                        if (first_idx[id] < 0) first_idx[id] = n;
                    end
                    nidx[id] = n + 1;
                    if (nidx[id] == w * h) phase[id] = 2;
                end
            end else begin
                exp_fd[id] = 1'b1;
                phase[id]  = 0;
            end
        end
    endtask

    // Single compare process for both instances, away from the rising edge.
    always @(negedge clk) begin
        step(0, 8, 8, a_start, a_pv, a_pix, a_pr, a_wv, a_wo, a_fd);
        step(1, 32, 32, b_start, b_pv, b_pix, b_pr, b_wv, b_wo, b_fd);
    end

    task automatic set_in(input int id, input logic st, input logic pv, input logic [7:0] px);
        if (id == 0) begin
            a_start = st; a_pv = pv; a_pix = px;
        end else begin
            b_start = st; b_pv = pv; b_pix = px;
        end
    endtask

    function automatic logic get_pr(input int id);
        return (id == 0) ? a_pr : b_pr;
    endfunction

    function automatic logic [7:0] pix_val(input int mode, input int n);
        if (mode == 0) return 8'(n);
        if (mode == 1) return 8'(255 - n);
        return 8'($urandom);
    endfunction

    // mode: 0 ramp, 1 inverted ramp, 2 random; abort_at < 0 runs the full frame.
    task automatic run_frame(input int id, input int w, input int h, input int mode, input int bubble,
                             input int abort_at, input logic mid_start, input logic done_start);
        int n, cyc;
        logic pv, st;
        logic [7:0] px;
        n = 0;
        cyc = 0;
        set_in(id, 1'b1, 1'b0, 8'd0);
        @(posedge clk); #1;
        px = pix_val(mode, 0);
        while (n < w * h && n != abort_at && cyc < 20000) begin
            pv = ($urandom_range(99) >= bubble);
            st = mid_start && (n == 20);
            set_in(id, st, pv, px);
            @(negedge clk);
            if (pv && get_pr(id)) begin
                n++;
                px = pix_val(mode, n);
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 20000) begin
            n_cmp++;
            n_err++;
            $display("FAIL frame_budget dut=%0d transfers=%0d exp=%0d", id, n, w * h);
        end
        if (n == abort_at) begin
            set_in(id, 1'b0, 1'b0, 8'd0);
        end else begin
            set_in(id, done_start, 1'b0, 8'd0);
            @(posedge clk); #1;
            set_in(id, 1'b0, 1'b0, 8'd0);
            repeat (4) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("reset_pix_ready", 0, 200'(a_pr), '0);
        chk("reset_win_out", 0, a_wo, '0);
        repeat (2) @(posedge clk);
        #1;

        // Ramp frame, continuous
        run_frame(0, 8, 8, 0, 0, -1, 1'b0, 1'b0);
        chk_i("ramp_count", 0, win_cnt[0], 16);
        chk_i("ramp_first_idx", 0, first_idx[0], 36);
        chk_i("ramp_first_if1", 0, tap(first_obs[0], 0), 0);
        chk_i("ramp_first_if5", 0, tap(first_obs[0], 4), 4);
        chk_i("ramp_first_if21", 0, tap(first_obs[0], 20), 32);
        chk_i("ramp_first_if25", 0, tap(first_obs[0], 24), 36);
        chk_i("ramp_last_if1", 0, tap(last_obs[0], 0), 27);
        chk_i("ramp_last_if25", 0, tap(last_obs[0], 24), 63);
        chk_i("ramp_done_count", 0, fd_cnt[0], 1);
        chk("ramp_ready_after", 0, 200'(a_pr), '0);

        // Default geometry, random pixels
        run_frame(1, 32, 32, 2, 0, -1, 1'b0, 1'b0);
        chk_i("dflt_count", 1, win_cnt[1], 784);
        chk_i("dflt_first_idx", 1, first_idx[1], 132);
        chk_i("dflt_done_count", 1, fd_cnt[1], 1);

        // Bubbles on pix_valid
        run_frame(0, 8, 8, 0, 50, -1, 1'b0, 1'b0);
        chk_i("bubble_count", 0, win_cnt[0], 16);
        chk_i("bubble_first_if25", 0, tap(first_obs[0], 24), 36);
        chk_i("bubble_last_if25", 0, tap(last_obs[0], 24), 63);

        // Start while busy and during DONE
        run_frame(0, 8, 8, 0, 20, -1, 1'b1, 1'b1);
        chk_i("busy_count", 0, win_cnt[0], 16);
        chk_i("busy_last_if1", 0, tap(last_obs[0], 0), 27);
        chk_i("busy_done_count", 0, fd_cnt[0], 1);
        chk("busy_ready_after", 0, 200'(a_pr), '0);

        // Reset mid-frame, right as a window is being presented
        run_frame(0, 8, 8, 0, 0, 40, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst_pix_ready", 0, 200'(a_pr), '0);
        chk("midrst_win_valid", 0, 200'(a_wv), '0);
        chk("midrst_frame_done", 0, 200'(a_fd), '0);
        chk("midrst_win_out", 0, a_wo, '0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_frame(0, 8, 8, 0, 0, -1, 1'b0, 1'b0);
        chk_i("after_rst_count", 0, win_cnt[0], 16);
        chk_i("after_rst_first_if25", 0, tap(first_obs[0], 24), 36);

        // Back-to-back frames with different content
        run_frame(0, 8, 8, 0, 0, -1, 1'b0, 1'b0);
        run_frame(0, 8, 8, 1, 0, -1, 1'b0, 1'b0);
        chk_i("b2b_count", 0, win_cnt[0], 16);
        chk_i("b2b_first_if1", 0, tap(first_obs[0], 0), 255);
        chk_i("b2b_first_if25", 0, tap(first_obs[0], 24), 219);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
